// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx_if
// Description : Word handshake between a data source and the piso_tx
//               serial transmitter.
//                 din        - parallel word (W bits), source -> transmitter
//                 din_valid  - din holds a word to send
//                 din_ready  - transmitter can accept a word this cycle
//               master modport: data source; slave modport: transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_tx_if #(
    parameter int W = 8
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx
// Description : Parallel-in serial-out framed transmitter. A word taken over
//               the valid/ready handshake is sent as
//               start(0) | W data bits | optional even parity | stop(1),
//               each bit held for CLKS_PER_BIT clocks.
// Ports       : clk   - system clock, rising edge
//               rst   - synchronous active-high reset
//               in_if - word handshake (slave side: din, din_valid, din_ready)
//               dout  - serial line, idles high
//               busy  - frame in progress
//               done  - one-cycle pulse in the first idle cycle after stop
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx #(
    parameter int W            = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int MSB_FIRST    = 0,
    parameter int PARITY_EN    = 1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    piso_tx_if.slave     in_if,
    output logic         dout,
    output logic         busy,
    output logic         done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] C_IDX_MAX = IW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [W-1:0]  shift_q, shift_d;
    logic          par_q,   par_d;
    logic          dout_q,  dout_d;
    logic          done_q,  done_d;
    logic          tick;

    // Ready is suppressed while reset is held so no accept can coincide
    // with reset.
    assign in_if.din_ready = (state_q == S_IDLE) && !rst;
    assign busy            = (state_q != S_IDLE);
    assign dout            = dout_q;
    assign done            = done_q;

    assign tick = (cnt_q == C_CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (in_if.din_valid) begin
                    shift_d = in_if.din;
                    par_d   = ^in_if.din;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick) begin
                    // Move the next bit toward the output end.
                    if (MSB_FIRST != 0) shift_d = shift_q << 1;
                    else                shift_d = shift_q >> 1;
                    if (idx_q == C_IDX_MAX) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is registered from the next state so dout is glitch
        // free and the start bit appears in the cycle right after accept.
        unique case (state_d)
            S_START:  dout_d = 1'b0;
            S_DATA:   dout_d = (MSB_FIRST != 0) ? shift_d[W-1] : shift_d[0];
            S_PARITY: dout_d = par_d;
            default:  dout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx
// Description : Self-checking bench for piso_tx. Four instances cover the
//               default configuration, MSB-first, MSB-first without parity
//               and a 4-clock bit period. Expected line levels are queued
//               when a word is offered and compared cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

    localparam int P_MSB [4] = '{0, 1, 1, 0};
    localparam int P_PAR [4] = '{1, 1, 0, 1};
    localparam int P_CPB [4] = '{1, 1, 1, 4};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_a [4];
    logic [3:0] vld;
    wire  [3:0] rdy;
    wire  [3:0] dout_w;
    wire  [3:0] busy_w;
    wire  [3:0] done_w;

    int   errors = 0;
    int   checks = 0;
    logic exp_q [$];

    always #5 clk = ~clk;

    piso_tx_if #(.W(8)) if0 ();
    piso_tx_if #(.W(8)) if1 ();
    piso_tx_if #(.W(8)) if2 ();
    piso_tx_if #(.W(8)) if3 ();

    assign if0.din = din_a[0];  assign if0.din_valid = vld[0];  assign rdy[0] = if0.din_ready;
    assign if1.din = din_a[1];  assign if1.din_valid = vld[1];  assign rdy[1] = if1.din_ready;
    assign if2.din = din_a[2];  assign if2.din_valid = vld[2];  assign rdy[2] = if2.din_ready;
    assign if3.din = din_a[3];  assign if3.din_valid = vld[3];  assign rdy[3] = if3.din_ready;

    piso_tx #(.W(8), .CLKS_PER_BIT(1), .MSB_FIRST(0), .PARITY_EN(1)) u0 (
        .clk(clk), .rst(rst), .in_if(if0), .dout(dout_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    piso_tx #(.W(8), .CLKS_PER_BIT(1), .MSB_FIRST(1), .PARITY_EN(1)) u1 (
        .clk(clk), .rst(rst), .in_if(if1), .dout(dout_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    piso_tx #(.W(8), .CLKS_PER_BIT(1), .MSB_FIRST(1), .PARITY_EN(0)) u2 (
        .clk(clk), .rst(rst), .in_if(if2), .dout(dout_w[2]), .busy(busy_w[2]), .done(done_w[2]));
    piso_tx #(.W(8), .CLKS_PER_BIT(4), .MSB_FIRST(0), .PARITY_EN(1)) u3 (
        .clk(clk), .rst(rst), .in_if(if3), .dout(dout_w[3]), .busy(busy_w[3]), .done(done_w[3]));

    // Reference frame: start, data in configured order, even parity, stop,
    // each level repeated for the bit period.
    function automatic void push_frame(int idx, logic [7:0] d);
        logic b [$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back((P_MSB[idx] != 0) ? d[7-i] : d[i]);
        if (P_PAR[idx] != 0) b.push_back(^d);
        b.push_back(1'b1);
        foreach (b[j]) for (int k = 0; k < P_CPB[idx]; k++) exp_q.push_back(b[j]);
    endfunction

    task automatic wait_ready(int idx);
        int k = 0;
        while (rdy[idx] !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (rdy[idx] !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout[%0d]: din_ready=%b required 1", idx, rdy[idx]);
        end
    endtask

    // Called at the negedge of the start-bit cycle; returns at the negedge
    // of the first idle cycle (the one carrying done).
    task automatic check_frame(int idx, string tag);
        int  n;
        logic e;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (dout_w[idx] !== e) begin
                errors++;
                $display("FAIL %s dout cycle %0d: got %b required %b", tag, i, dout_w[idx], e);
            end
            checks++;
            if ({rdy[idx], busy_w[idx], done_w[idx]} !== 3'b010) begin
                errors++;
                $display("FAIL %s ctl cycle %0d: ready/busy/done=%b required 010",
                         tag, i, {rdy[idx], busy_w[idx], done_w[idx]});
            end
            @(negedge clk);
        end
        checks++;
        if ({dout_w[idx], rdy[idx], busy_w[idx], done_w[idx]} !== 4'b1101) begin
            errors++;
            $display("FAIL %s end: dout/ready/busy/done=%b required 1101",
                     tag, {dout_w[idx], rdy[idx], busy_w[idx], done_w[idx]});
        end
    endtask

    task automatic check_done_low(int idx, string tag);
        checks++;
        if ({done_w[idx], busy_w[idx], dout_w[idx]} !== 3'b001) begin
            errors++;
            $display("FAIL %s after: done/busy/dout=%b required 001",
                     tag, {done_w[idx], busy_w[idx], dout_w[idx]});
        end
    endtask

    task automatic send_frame(int idx, logic [7:0] d, string tag);
        wait_ready(idx);
        din_a[idx] = d;
        vld[idx]   = 1'b1;
        push_frame(idx, d);
        @(negedge clk);
        vld[idx]   = 1'b0;
        din_a[idx] = ~d;
        check_frame(idx, tag);
        @(negedge clk);
        check_done_low(idx, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({dout_w[i], rdy[i], busy_w[i], done_w[i]} !== 4'b1000) begin
                    errors++;
                    $display("FAIL reset[%0d]: dout/ready/busy/done=%b required 1000",
                             i, {dout_w[i], rdy[i], busy_w[i], done_w[i]});
                end
            end
        end
        vld = 4'h0;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({dout_w[i], rdy[i], busy_w[i], done_w[i]} !== 4'b1100) begin
                    errors++;
                    $display("FAIL post_reset[%0d]: dout/ready/busy/done=%b required 1100",
                             i, {dout_w[i], rdy[i], busy_w[i], done_w[i]});
                end
            end
        end
    endtask

    task automatic test_basic();
        send_frame(0, 8'hB4, "basic_b4");
        send_frame(0, 8'h00, "basic_00");
        send_frame(0, 8'h7E, "basic_7e");
        send_frame(0, 8'($urandom_range(0, 255)), "basic_rand");
    endtask

    task automatic test_order_parity();
        send_frame(1, 8'hB5, "msb_b5");
        send_frame(1, 8'h80, "msb_80");
        send_frame(2, 8'hB5, "nopar_b5");
        send_frame(2, 8'h3C, "nopar_3c");
    endtask

    task automatic test_stretch();
        send_frame(3, 8'h01, "cpb4_01");
        send_frame(3, 8'hC3, "cpb4_c3");
    endtask

    task automatic test_back_to_back();
        wait_ready(0);
        din_a[0] = 8'hFF;
        vld[0]   = 1'b1;
        push_frame(0, 8'hFF);
        @(negedge clk);
        din_a[0] = 8'h00;          // changed mid-frame, valid left high
        check_frame(0, "b2b_ff");
        push_frame(0, 8'h00);      // accepted on the edge after done
        @(negedge clk);
        vld[0]   = 1'b0;
        check_frame(0, "b2b_00");
        @(negedge clk);
        check_done_low(0, "b2b_00");
    endtask

    task automatic test_reset_mid();
        logic e;
        wait_ready(0);
        din_a[0] = 8'hA5;
        vld[0]   = 1'b1;
        push_frame(0, 8'hA5);
        @(negedge clk);
        vld[0] = 1'b0;
        // start bit plus data bits 0..3
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (dout_w[0] !== e) begin
                errors++;
                $display("FAIL rst_mid dout cycle %0d: got %b required %b", i, dout_w[0], e);
            end
            if (i < 4) @(negedge clk);
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({dout_w[0], rdy[0], busy_w[0], done_w[0]} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid abort: dout/ready/busy/done=%b required 1000",
                     {dout_w[0], rdy[0], busy_w[0], done_w[0]});
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({dout_w[0], rdy[0], busy_w[0], done_w[0]} !== 4'b1100) begin
                errors++;
                $display("FAIL rst_mid idle %0d: dout/ready/busy/done=%b required 1100",
                         c, {dout_w[0], rdy[0], busy_w[0], done_w[0]});
            end
        end
        send_frame(0, 8'hA5, "rst_mid_resend");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din_a[i] = 8'h00;
        vld = 4'h0;
        test_reset();
        test_basic();
        test_order_parity();
        test_stretch();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
